// File: rtl/uart_tx_cfg_if.sv
// Bus-side bundle of the configurable UART transmitter:
// FIFO write port, frame configuration, serial line and status.
interface uart_tx_cfg_if #(
  parameter int DATA_WIDTH = 9,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic                  tx_en_i;
  logic                  tx_we_i;
  logic [DATA_WIDTH-1:0] din_i;
  logic [DIV_WIDTH-1:0]  baud_div_i;
  logic [3:0]            data_bits_i;
  logic [1:0]            parity_i;
  logic                  stop2_i;
  logic                  tx_o;
  logic                  full_o;
  logic                  empty_o;
  logic [LW-1:0]         level_o;
  logic                  busy_o;
  logic                  done_o;

  modport master (
    output tx_en_i, tx_we_i, din_i, baud_div_i,
    output data_bits_i, parity_i, stop2_i,
    input  tx_o, full_o, empty_o, level_o,
    input  busy_o, done_o
  );

  modport slave (
    input  tx_en_i, tx_we_i, din_i, baud_div_i,
    input  data_bits_i, parity_i, stop2_i,
    output tx_o, full_o, empty_o, level_o,
    output busy_o, done_o
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with a FWFT TX FIFO.
// Frame settings are latched on every pop and held for the frame.
module uart_tx_cfg #(
  parameter int DATA_WIDTH = 9,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input logic          clk_i,
  input logic          rst_i,
  uart_tx_cfg_if.slave bus
);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0]    NMAX   = 4'(DATA_WIDTH);
  localparam logic [LW-1:0] FULL_L = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wptr_q, rptr_q;
  logic [LW-1:0]         level_q;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DIV_WIDTH-1:0]  baud_q, baud_d;
  logic [3:0]            nbits_q, nbits_d;
  logic [3:0]            bit_q, bit_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  stop2_q, stop2_d;
  logic                  stop_q, stop_d;
  logic                  tx_q, tx_d;

  logic                  full, empty;
  logic                  bit_end, last_stop;
  logic                  pop, push;
  logic [3:0]            n_in;
  logic [DATA_WIDTH-1:0] mask, head;

  assign head  = mem_q[rptr_q];
  assign full  = (level_q == FULL_L);
  assign empty = (level_q == '0);

  assign bit_end   = (baud_q == div_q - DIV_WIDTH'(1));
  assign last_stop = (state_q == STOP) && bit_end &&
                     (stop_q == stop2_q);

  assign pop  = bus.tx_en_i && !empty &&
                ((state_q == IDLE) || last_stop);
  assign push = bus.tx_we_i && (!full || pop);

  always_comb begin
    n_in = bus.data_bits_i;
    if (n_in < 4'd5) n_in = 4'd5;
    else if (n_in > NMAX) n_in = NMAX;
  end

  // Parity only covers the bits that actually go on the wire.
  always_comb begin
    mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      mask[i] = (i < int'(n_in));
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= bus.din_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    div_d     = div_q;
    baud_d    = baud_q;
    nbits_d   = nbits_q;
    bit_d     = bit_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    stop_d    = stop_q;

    if (state_q != IDLE)
      baud_d = bit_end ? '0 : baud_q + DIV_WIDTH'(1);

    unique case (state_q)
      IDLE: ;
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == nbits_q - 4'd1) begin
            state_d = par_en_q ? PARITY : STOP;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          stop_d  = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_q == stop2_q) state_d = IDLE;
          else stop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop overrides the end-of-frame return to IDLE.
    if (pop) begin
      state_d   = START;
      shift_d   = head;
      nbits_d   = n_in;
      par_en_d  = (bus.parity_i == 2'b01) ||
                  (bus.parity_i == 2'b10);
      par_bit_d = (^(head & mask)) ^
                  (bus.parity_i == 2'b10);
      stop2_d   = bus.stop2_i;
      div_d     = (bus.baud_div_i == '0) ?
                  DIV_WIDTH'(1) : bus.baud_div_i;
      baud_d    = '0;
    end

    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      div_q     <= DIV_WIDTH'(1);
      baud_q    <= '0;
      nbits_q   <= '0;
      bit_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      stop_q    <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
      baud_q    <= baud_d;
      nbits_q   <= nbits_d;
      bit_q     <= bit_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      stop_q    <= stop_d;
      tx_q      <= tx_d;
    end
  end

  assign bus.tx_o    = tx_q;
  assign bus.full_o  = full;
  assign bus.empty_o = empty;
  assign bus.level_o = level_q;
  assign bus.busy_o  = (state_q != IDLE);
  assign bus.done_o  = last_stop;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: table of frame vectors
// plus hand sequences for FIFO fill, mid-frame changes and reset.
module tb_uart_tx_cfg;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  uart_tx_cfg_if #(
    .DATA_WIDTH(9), .FIFO_DEPTH(16), .DIV_WIDTH(16)
  ) bus ();

  uart_tx_cfg #(
    .DATA_WIDTH(9), .FIFO_DEPTH(16), .DIV_WIDTH(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0]  nb;
    logic [1:0]  par;
    logic        st2;
    logic [15:0] div;
    logic [8:0]  din;
    logic [15:0] bits;
    int          len;
    int          d;
  } vec_t;

  vec_t vecs[7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_cfg(input logic [3:0] nb,
                         input logic [1:0] par,
                         input logic st2,
                         input logic [15:0] div);
    bus.data_bits_i = nb;
    bus.parity_i    = par;
    bus.stop2_i     = st2;
    bus.baud_div_i  = div;
  endtask

  // Entered #1 after the edge that starts the frame.
  task automatic check_frame(input logic [15:0] bits,
                             input int nb, input int d,
                             input int id);
    int last;
    last = nb * d - 1;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      chk($sformatf("f%0d_tx_c%0d", id, c),
          32'(bus.tx_o), 32'(bits[c / d]));
      chk($sformatf("f%0d_done_c%0d", id, c),
          32'(bus.done_o), 32'(c == last));
      chk($sformatf("f%0d_busy_c%0d", id, c),
          32'(bus.busy_o), 32'd1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_vec(input int i);
    set_cfg(vecs[i].nb, vecs[i].par, vecs[i].st2, vecs[i].div);
    bus.din_i   = vecs[i].din;
    bus.tx_we_i = 1'b1;
    bus.tx_en_i = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_we_i = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_empty_lat", i), 32'(bus.empty_o), 32'd0);
    chk($sformatf("v%0d_busy_lat", i), 32'(bus.busy_o), 32'd0);
    @(posedge clk);
    #1;
    check_frame(vecs[i].bits, vecs[i].len, vecs[i].d, i);
    @(negedge clk);
    chk($sformatf("v%0d_busy_end", i), 32'(bus.busy_o), 32'd0);
    chk($sformatf("v%0d_tx_idle", i), 32'(bus.tx_o), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    vecs[0] = '{4'd8, 2'b00, 1'b0, 16'd4, 9'h0A5,
                16'({1'b1, 8'hA5, 1'b0}), 10, 4};
    vecs[1] = '{4'd7, 2'b01, 1'b0, 16'd3, 9'h007,
                16'({1'b1, 1'b1, 7'h07, 1'b0}), 10, 3};
    vecs[2] = '{4'd7, 2'b10, 1'b0, 16'd3, 9'h007,
                16'({1'b1, 1'b0, 7'h07, 1'b0}), 10, 3};
    vecs[3] = '{4'd5, 2'b00, 1'b1, 16'd2, 9'h1FF,
                16'({2'b11, 5'h1F, 1'b0}), 8, 2};
    vecs[4] = '{4'd9, 2'b11, 1'b0, 16'd0, 9'h136,
                16'({1'b1, 9'h136, 1'b0}), 11, 1};
    vecs[5] = '{4'd3, 2'b01, 1'b0, 16'd2, 9'h00B,
                16'({1'b1, 1'b1, 5'h0B, 1'b0}), 8, 2};
    vecs[6] = '{4'd15, 2'b10, 1'b0, 16'd2, 9'h1FF,
                16'({1'b1, 1'b0, 9'h1FF, 1'b0}), 12, 2};

    rst         = 1'b1;
    bus.tx_en_i = 1'b0;
    bus.tx_we_i = 1'b0;
    bus.din_i   = '0;
    set_cfg(4'd8, 2'b00, 1'b0, 16'd4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", 32'(bus.tx_o), 32'd1);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_empty", 32'(bus.empty_o), 32'd1);
    chk("rst_full", 32'(bus.full_o), 32'd0);
    chk("rst_level", 32'(bus.level_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i);

    // Fill past capacity with the transmitter disabled.
    bus.tx_en_i = 1'b0;
    set_cfg(4'd8, 2'b00, 1'b0, 16'd1);
    for (int i = 0; i < 17; i++) begin
      bus.din_i   = 9'(64 + i);
      bus.tx_we_i = 1'b1;
      @(posedge clk);
      #1;
      bus.tx_we_i = 1'b0;
      @(negedge clk);
      chk($sformatf("fill_level_%0d", i),
          32'(bus.level_o), (i < 16) ? 32'(i + 1) : 32'd16);
    end
    chk("fill_full", 32'(bus.full_o), 32'd1);
    chk("fill_empty", 32'(bus.empty_o), 32'd0);
    @(posedge clk);
    #1;
    bus.tx_en_i = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 16; k++)
      check_frame(16'({1'b1, 8'(64 + k), 1'b0}), 10, 1, 200 + k);
    @(negedge clk);
    chk("drain_busy", 32'(bus.busy_o), 32'd0);
    chk("drain_empty", 32'(bus.empty_o), 32'd1);
    chk("drain_level", 32'(bus.level_o), 32'd0);
    chk("drain_tx", 32'(bus.tx_o), 32'd1);
    @(posedge clk);
    #1;

    // Mid-frame config change and enable drop.
    set_cfg(4'd8, 2'b00, 1'b0, 16'd4);
    bus.din_i   = 9'h03C;
    bus.tx_we_i = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_we_i = 1'b0;
    @(posedge clk);
    #1;
    fork
      check_frame(16'({1'b1, 8'h3C, 1'b0}), 10, 4, 100);
      begin
        repeat (10) @(posedge clk);
        #1;
        set_cfg(4'd5, 2'b01, 1'b1, 16'd1);
        bus.tx_en_i = 1'b0;
        bus.din_i   = 9'h055;
        bus.tx_we_i = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_we_i = 1'b0;
      end
    join
    @(negedge clk);
    chk("mid_busy", 32'(bus.busy_o), 32'd0);
    chk("mid_tx", 32'(bus.tx_o), 32'd1);
    chk("mid_level", 32'(bus.level_o), 32'd1);
    repeat (3) @(negedge clk);
    chk("mid_stay_idle", 32'(bus.busy_o), 32'd0);
    @(posedge clk);
    #1;

    // Async reset during data bit 1 of 0x055 (a zero bit).
    set_cfg(4'd8, 2'b00, 1'b0, 16'd4);
    bus.tx_en_i = 1'b1;
    @(posedge clk);
    #1;
    bus.din_i   = 9'h0AA;
    bus.tx_we_i = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_we_i = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_rst_tx", 32'(bus.tx_o), 32'd0);
    chk("pre_rst_empty", 32'(bus.empty_o), 32'd0);
    chk("pre_rst_busy", 32'(bus.busy_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_tx", 32'(bus.tx_o), 32'd1);
    chk("arst_empty", 32'(bus.empty_o), 32'd1);
    chk("arst_busy", 32'(bus.busy_o), 32'd0);
    chk("arst_level", 32'(bus.level_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy_o), 32'd0);
    chk("post_rst_tx", 32'(bus.tx_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
